// File: rtl/fetch_sequencer_if.sv
// Fetch/execute handshake bundle between the sequencer, instruction memory and datapath.
interface fetch_sequencer_if #(
  parameter int unsigned XLEN = 64
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  logic [31:0]     instr;
  logic            exec_done;
  logic            branch;
  logic            zero;
  logic [XLEN-1:0] imm;
  logic            halt_req;

  modport master (
    output imem_req, imem_addr, instr_valid, instr,
    input  imem_ack, imem_rdata, exec_done, branch, zero, imm, halt_req
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr,
    output imem_ack, imem_rdata, exec_done, branch, zero, imm, halt_req
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC owner: fetches from variable-latency imem, hands instructions to the datapath,
// advances the PC on completion and stops on halt, fetch timeout or misaligned target.
module fetch_sequencer #(
  parameter int unsigned     XLEN          = 64,
  parameter logic [XLEN-1:0] RESET_PC      = '0,
  parameter int unsigned     FETCH_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  fetch_sequencer_if.master   bus,
  output logic [XLEN-1:0]     pc,
  output logic [31:0]         retired,
  output logic                halted,
  output logic [1:0]          fault
);

  localparam int unsigned     CNT_W    = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd1;
  localparam logic [1:0] FAULT_ALIGN   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [XLEN-1:0]  next_pc;

  // Candidate PC after the current instruction; wraps modulo 2^XLEN.
  assign next_pc = (bus.branch && bus.zero) ? pc + bus.imm : pc + XLEN'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      bus.imem_req    <= 1'b0;
      bus.imem_addr   <= RESET_PC;
      bus.instr_valid <= 1'b0;
      bus.instr       <= 32'h0;
      retired         <= 32'h0;
      halted          <= 1'b0;
      fault           <= FAULT_NONE;
      wait_cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state         <= FETCH;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= pc;
          end
        end

        // Ack beats the timeout when both land on the same edge.
        FETCH: begin
          if (bus.imem_ack) begin
            state           <= EXEC;
            bus.instr       <= bus.imem_rdata;
            bus.imem_req    <= 1'b0;
            bus.instr_valid <= 1'b1;
            wait_cnt        <= '0;
          end else if (wait_cnt == CNT_LAST) begin
            state        <= HALT;
            bus.imem_req <= 1'b0;
            halted       <= 1'b1;
            fault        <= FAULT_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        // A misaligned target faults before retire, even on a halt instruction.
        EXEC: begin
          if (bus.exec_done) begin
            bus.instr_valid <= 1'b0;
            if (next_pc[1:0] != 2'b00) begin
              state  <= HALT;
              halted <= 1'b1;
              fault  <= FAULT_ALIGN;
            end else begin
              pc      <= next_pc;
              retired <= retired + 32'd1;
              if (bus.halt_req) begin
                state  <= HALT;
                halted <= 1'b1;
              end else begin
                state         <= FETCH;
                bus.imem_req  <= 1'b1;
                bus.imem_addr <= next_pc;
              end
            end
          end
        end

        HALT: begin
          state <= HALT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a transaction-level PC/retire model checked every cycle.
module tb_fetch_sequencer;
  localparam int unsigned XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int unsigned TMO      = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] pc;
  logic [31:0] retired;
  logic        halted;
  logic [1:0]  fault;

  fetch_sequencer_if #(.XLEN(XLEN)) bus();

  fetch_sequencer #(.XLEN(XLEN), .RESET_PC(RESET_PC), .FETCH_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .pc(pc), .retired(retired), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Model of architecturally visible state
  logic [63:0] m_pc;
  logic [31:0] m_retired;
  logic        m_halted;
  logic [1:0]  m_fault;
  logic        m_req;
  logic        m_iv;
  logic [31:0] m_instr;
  bit          chk_en = 1'b0;
  int          req_cycles = 0;
  int          iv_cycles = 0;
  int          n_checks = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("retired", 64'(retired), 64'(m_retired));
      chk("halted", 64'(halted), 64'(m_halted));
      chk("fault", 64'(fault), 64'(m_fault));
      chk("imem_req", 64'(bus.imem_req), 64'(m_req));
      chk("instr_valid", 64'(bus.instr_valid), 64'(m_iv));
      if (bus.imem_req) chk("imem_addr", bus.imem_addr, m_pc);
      if (bus.instr_valid) chk("instr", 64'(bus.instr), 64'(m_instr));
      if (bus.imem_req) req_cycles++;
      if (bus.instr_valid) iv_cycles++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_retired = 32'h0; m_halted = 1'b0; m_fault = 2'd0;
    m_req = 1'b0; m_iv = 1'b0; m_instr = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic begin_fetch();
    start = 1'b1;
    step();
    start = 1'b0;
    if (!m_halted) m_req = 1'b1;
  endtask

  // Holds ack low for 'waits' FETCH cycles (optionally with stray exec_done), then acks.
  task automatic fetch(input int waits, input logic [31:0] word, input logic noise);
    for (int i = 0; i < waits; i++) begin
      bus.imem_ack = 1'b0;
      bus.exec_done = noise; bus.branch = noise; bus.zero = noise; bus.imm = 64'h8;
      step();
    end
    bus.exec_done = 1'b0; bus.branch = 1'b0; bus.zero = 1'b0; bus.imm = 64'h0;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = word;
    step();
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    m_instr = word; m_req = 1'b0; m_iv = 1'b1;
  endtask

  task automatic execute(input int delay, input logic br, input logic z,
                         input logic [63:0] im, input logic hr);
    logic [63:0] nxt;
    for (int i = 0; i < delay; i++) begin
      bus.exec_done = 1'b0;
      step();
    end
    bus.exec_done = 1'b1; bus.branch = br; bus.zero = z; bus.imm = im; bus.halt_req = hr;
    step();
    bus.exec_done = 1'b0; bus.branch = 1'b0; bus.zero = 1'b0; bus.imm = 64'h0; bus.halt_req = 1'b0;
    nxt = (br && z) ? m_pc + im : m_pc + 64'd4;
    m_iv = 1'b0;
    if (nxt[1:0] != 2'b00) begin
      m_halted = 1'b1; m_fault = 2'd2; m_req = 1'b0;
    end else begin
      m_pc = nxt;
      m_retired = m_retired + 32'd1;
      if (hr) begin m_halted = 1'b1; m_req = 1'b0; end
      else m_req = 1'b1;
    end
  endtask

  task automatic run(input logic br, input logic z, input logic [63:0] im, input logic hr);
    fetch(0, 32'h0000_0013, 1'b0);
    execute(0, br, z, im, hr);
  endtask

  int base_req;
  int base_iv;

  initial begin
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.exec_done = 1'b0;
    bus.branch = 1'b0; bus.zero = 1'b0; bus.imm = 64'h0; bus.halt_req = 1'b0;
    model_reset();
    chk_en = 1'b1;
    do_reset();

    chk("rst_pc", pc, 64'h0);
    chk("rst_addr", bus.imem_addr, 64'h0);
    chk("rst_instr", 64'(bus.instr), 64'h0);
    chk("rst_retired", 64'(retired), 64'h0);

    // Basic fetch: ack in 3rd FETCH cycle, exec_done in 2nd EXEC cycle
    base_req = req_cycles; base_iv = iv_cycles;
    begin_fetch();
    fetch(2, 32'h0000_0013, 1'b1);
    chk("t1_instr", 64'(bus.instr), 64'h13);
    execute(1, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("t1_req_cycles", 64'(req_cycles - base_req), 64'd3);
    chk("t1_iv_cycles", 64'(iv_cycles - base_iv), 64'd2);
    chk("t1_pc", pc, 64'h4);
    chk("t1_retired", 64'(retired), 64'd1);

    for (int i = 0; i < 3; i++) run(1'b0, 1'b0, 64'h0, 1'b0);
    chk("seq_pc", pc, 64'h10);
    run(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    chk("br_not_taken", pc, 64'h14);
    run(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    chk("br_back", pc, 64'h10);
    run(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    chk("br_taken", pc, 64'h08);
    run(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0);
    chk("top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    run(1'b0, 1'b0, 64'h0, 1'b0);
    chk("wrap_pc", pc, 64'h0);
    chk("wrap_fault", 64'(fault), 64'd0);
    run(1'b1, 1'b1, 64'h2, 1'b0);
    chk("mis_fault", 64'(fault), 64'd2);
    chk("mis_halted", 64'(halted), 64'd1);
    chk("mis_pc", pc, 64'h0);
    chk("mis_retired", 64'(retired), 64'd9);

    // Timeout: no ack for exactly TMO FETCH cycles
    do_reset();
    base_req = req_cycles;
    begin_fetch();
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      bus.imem_ack = 1'b0;
      step();
    end
    chk("tmo_not_yet", 64'(halted), 64'd0);
    step();
    m_halted = 1'b1; m_fault = 2'd1; m_req = 1'b0;
    chk("tmo_fault", 64'(fault), 64'd1);
    chk("tmo_halted", 64'(halted), 64'd1);
    chk("tmo_req_cycles", 64'(req_cycles - base_req), 64'd16);
    chk("tmo_pc", pc, 64'h0);

    // Ack on the last allowed cycle wins, then halt instruction at 0x20
    do_reset();
    begin_fetch();
    fetch(int'(TMO) - 1, 32'h0000_0063, 1'b0);
    chk("late_ack_fault", 64'(fault), 64'd0);
    chk("late_ack_iv", 64'(bus.instr_valid), 64'd1);
    execute(0, 1'b1, 1'b1, 64'h20, 1'b0);
    chk("jmp_pc", pc, 64'h20);
    run(1'b0, 1'b0, 64'h0, 1'b1);
    chk("halt_pc", pc, 64'h24);
    chk("halt_retired", 64'(retired), 64'd2);
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_fault", 64'(fault), 64'd0);
    start = 1'b1;
    for (int i = 0; i < 3; i++) step();
    start = 1'b0;
    chk("halt_sticky", 64'(halted), 64'd1);

    // Asynchronous reset in the middle of a FETCH cycle, late ack ignored
    do_reset();
    begin_fetch();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", 64'(bus.imem_req), 64'd0);
    chk("arst_pc", pc, RESET_PC);
    model_reset();
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    step();
    rst = 1'b0;
    step();
    step();
    bus.imem_ack = 1'b0;
    chk("late_ack_idle_req", 64'(bus.imem_req), 64'd0);
    chk("late_ack_idle_instr", 64'(bus.instr), 64'h0);
    begin_fetch();
    run(1'b0, 1'b0, 64'h0, 1'b0);
    chk("recover_pc", pc, 64'h4);

    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
